encoded_memory_sequencer: RTL and testbench

Upstream controller for the encoded-memory stage (ROM mask + difference RAM). It accepts eight bytes over a valid/ready stream and writes them into slots 0..7 in order; the memory stores |mask[i] − byte|. It then sweeps all eight slots in read mode and streams the stored values out with their slot index. It also reports the sum and maximum of the read-back values.

---
 rtl/encoded_memory_sequencer.sv | 146 ++++++++++++++
 tb/tb_encoded_memory_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoded_memory_sequencer.sv
// -----------------------------------------------------------------------------
// encoded_memory_sequencer
//
// Upstream controller for the encoded-memory stage (ROM mask + difference RAM).
// A pass loads eight bytes from a valid/ready stream into slots 0..7 (the
// memory itself stores |mask[i] - byte|), then sweeps all eight slots in read
// mode, streaming each stored value out with its slot index while keeping a
// running sum and maximum of the read-back values.
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous, active-high reset
//   start       begin a pass; honoured only in IDLE or DONE
//   in_valid    in_data carries a byte to store
//   in_data     byte to store
//   in_ready    sequencer accepts a byte this cycle (combinational)
//   mem_mode    memory mode, 0 = write, 1 = read (combinational)
//   mem_index   memory slot address (combinational)
//   mem_number  memory write data (combinational, always in_data)
//   mem_result  memory combinational read data
//   out_valid   out_data/out_index valid this cycle
//   out_data    read-back value
//   out_index   slot of out_data
//   sum         running unsigned sum of read-back values
//   max         running unsigned maximum of read-back values
//   done        pass complete, sum/max final
// -----------------------------------------------------------------------------
module encoded_memory_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_mode,
    output logic [2:0]  mem_index,
    output logic [7:0]  mem_number,
    input  logic [7:0]  mem_result,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [2:0]  out_index,
    output logic [10:0] sum,
    output logic [7:0]  max,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wr_cnt;
    logic [2:0] rd_cnt;
    logic       clear;

    // A pass (re)starts only from IDLE or DONE; start is ignored mid-pass.
    assign clear = start && (state == IDLE || state == DONE);

    // Next-state logic and the combinational memory/handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement leaves one unassigned (no latches).
        state_nxt  = state;
        in_ready   = 1'b0;
        mem_mode   = 1'b1;
        mem_index  = 3'd0;
        mem_number = in_data;

        case (state)
            IDLE: begin
                if (start) state_nxt = WRITE;
            end
            WRITE: begin
                in_ready  = 1'b1;
                mem_index = wr_cnt;
                // The memory writes on every edge in mode 0, so write mode is
                // asserted only when a byte is really being handed over.
                if (in_valid) begin
                    mem_mode = 1'b0;
                    if (wr_cnt == 3'd7) state_nxt = READ;
                end
            end
            READ: begin
                mem_index = rd_cnt;
                if (rd_cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = WRITE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_cnt    <= 3'd0;
            rd_cnt    <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_index <= 3'd0;
            sum       <= 11'd0;
            max       <= 8'd0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (clear) begin
                wr_cnt <= 3'd0;
                rd_cnt <= 3'd0;
                sum    <= 11'd0;
                max    <= 8'd0;
                done   <= 1'b0;
            end

            // The 3-bit wrap 7 -> 0 coincides with the WRITE -> READ move.
            if (state == WRITE && in_valid) begin
                wr_cnt <= wr_cnt + 3'd1;
            end

            if (state == READ) begin
                out_valid <= 1'b1;
                out_data  <= mem_result;
                out_index <= rd_cnt;
                sum       <= sum + {3'b000, mem_result};
                if (mem_result > max) max <= mem_result;
                rd_cnt    <= rd_cnt + 3'd1;
                // The last read-back word and done appear together.
                if (rd_cnt == 3'd7) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encoded_memory_sequencer.sv
// -----------------------------------------------------------------------------
// tb_encoded_memory_sequencer
//
// Self-checking bench for encoded_memory_sequencer. A behavioural difference
// RAM (ROM mask + |mask - byte| store, combinational read) sits on the memory
// port. Expected read-back streams come from a table of known passes and from
// a plain-arithmetic reference model for randomized passes.
// -----------------------------------------------------------------------------
module tb_encoded_memory_sequencer;

    typedef logic [7:0][7:0] vec8_t;   // element [i] is slot i

    typedef struct {
        vec8_t       din;
        vec8_t       dout;
        logic [10:0] exp_sum;
        logic [7:0]  exp_max;
    } vec_t;

    localparam logic [7:0] MASK [8] = '{8'h00, 8'h55, 8'hAA, 8'h33,
                                        8'hCC, 8'h0F, 8'hF0, 8'hFF};

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_mode;
    logic [2:0]  mem_index;
    logic [7:0]  mem_number;
    logic [7:0]  mem_result;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_index;
    logic [10:0] sum;
    logic [7:0]  max;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    encoded_memory_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_mode   (mem_mode),
        .mem_index  (mem_index),
        .mem_number (mem_number),
        .mem_result (mem_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .sum        (sum),
        .max        (max),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Behavioural encoded memory: writes on every rising edge in mode 0.
    logic [7:0] ram [8];
    always @(posedge CLK) begin
        if (!mem_mode) begin
            ram[mem_index] <= (mem_number > MASK[mem_index]) ?
                              mem_number - MASK[mem_index] :
                              MASK[mem_index] - mem_number;
        end
    end
    assign mem_result = ram[mem_index];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec8_t mk(input logic [7:0] b0, b1, b2, b3,
                                 b4, b5, b6, b7);
        vec8_t v;
        v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
        v[4] = b4; v[5] = b5; v[6] = b6; v[7] = b7;
        return v;
    endfunction

    // Reference model: stored value is the absolute difference from the mask.
    task automatic ref_pass(input vec8_t b, output vec_t r);
        int s = 0;
        int m = 0;
        r.din = b;
        for (int i = 0; i < 8; i++) begin
            int d = int'(b[i]) - int'(MASK[i]);
            if (d < 0) d = -d;
            r.dout[i] = 8'(d);
            s += d;
            if (d > m) m = d;
        end
        r.exp_sum = 11'(s);
        r.exp_max = 8'(m);
    endtask

    // One complete pass starting at a negedge with the DUT in IDLE or DONE.
    // gap: idle cycles before each handshake; noise: drive start high during
    // gaps and READ; vws: in_valid high together with start.
    task automatic do_pass(input vec_t v, input int gap, input bit noise,
                           input bit vws, input string tag);
        int  cnt  = 0;
        bit  seen = 0;
        start    = 1'b1;
        in_valid = vws;
        in_data  = 8'h12;
        #1;
        check({tag, " start mem_mode"}, mem_mode, 1);
        check({tag, " start in_ready"}, in_ready, 0);
        @(negedge CLK);
        start = 1'b0;
        check({tag, " cleared done"}, done, 0);
        check({tag, " cleared sum"}, sum, 0);
        check({tag, " cleared max"}, max, 0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'hAB;
                start    = noise;
                #1;
                check($sformatf("%s gap mem_mode %0d", tag, i), mem_mode, 1);
                @(negedge CLK);
            end
            in_valid = 1'b1;
            in_data  = v.din[i];
            start    = noise;
            #1;
            check($sformatf("%s wr in_ready %0d", tag, i), in_ready, 1);
            check($sformatf("%s wr mem_mode %0d", tag, i), mem_mode, 0);
            check($sformatf("%s wr mem_index %0d", tag, i), mem_index, i);
            check($sformatf("%s wr mem_number %0d", tag, i), mem_number,
                  v.din[i]);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (out_valid) begin
                check($sformatf("%s out_index %0d", tag, cnt), out_index, cnt);
                check($sformatf("%s out_data %0d", tag, cnt), out_data,
                      v.dout[cnt]);
                cnt++;
                check($sformatf("%s done at read %0d", tag, cnt), done,
                      cnt == 8);
            end
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end
        end
        check({tag, " valid count"}, cnt, 8);
        check({tag, " sum"}, sum, v.exp_sum);
        check({tag, " max"}, max, v.exp_max);
        @(negedge CLK);
        check({tag, " post out_valid"}, out_valid, 0);
        check({tag, " post done"}, done, 1);
        check({tag, " post sum hold"}, sum, v.exp_sum);
        check({tag, " post in_ready"}, in_ready, 0);
    endtask

    vec_t table_v [3];
    vec_t rv;

    initial begin
        // Known passes from the mask values.
        table_v[0].din     = '0;
        table_v[0].dout    = mk(8'h00, 8'h55, 8'hAA, 8'h33,
                                8'hCC, 8'h0F, 8'hF0, 8'hFF);
        table_v[0].exp_sum = 11'd1020;
        table_v[0].exp_max = 8'hFF;
        table_v[1].din     = mk(8'h00, 8'h55, 8'hAA, 8'h33,
                                8'hCC, 8'h0F, 8'hF0, 8'hFF);
        table_v[1].dout    = '0;
        table_v[1].exp_sum = 11'd0;
        table_v[1].exp_max = 8'h00;
        table_v[2].din     = {8{8'hFF}};
        table_v[2].dout    = mk(8'hFF, 8'hAA, 8'h55, 8'hCC,
                                8'h33, 8'hF0, 8'h0F, 8'h00);
        table_v[2].exp_sum = 11'd1020;
        table_v[2].exp_max = 8'hFF;

        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h5A;
        repeat (2) @(negedge CLK);
        check("rst in_ready", in_ready, 0);
        check("rst mem_mode", mem_mode, 1);
        check("rst mem_index", mem_index, 0);
        check("rst mem_number", mem_number, 8'h5A);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_index", out_index, 0);
        check("rst sum", sum, 0);
        check("rst max", max, 0);
        check("rst done", done, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle in_ready", in_ready, 0);

        // Table-driven passes, back to back (each restarts from DONE).
        for (int t = 0; t < 3; t++) begin
            do_pass(table_v[t], 0, 1'b0, 1'b0, $sformatf("tbl%0d", t));
        end

        // DONE holds while start stays low.
        repeat (3) @(negedge CLK);
        check("done hold", done, 1);
        check("done hold sum", sum, 11'd1020);

        // Gapped zero load with start noise; 0xAB must never reach memory.
        do_pass(table_v[0], 3, 1'b1, 1'b0, "gap");

        // Reset mid-READ.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        begin
            bit hit = 0;
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge CLK);
                if (out_valid && out_index == 3'd3) hit = 1;
            end
            check("midread reached index 3", hit, 1);
        end
        RST = 1'b1;
        #1;
        check("midread rst out_valid", out_valid, 0);
        check("midread rst done", done, 0);
        check("midread rst sum", sum, 0);
        check("midread rst max", max, 0);
        @(negedge CLK);
        RST      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check("after rst idle in_ready", in_ready, 0);
        check("after rst idle mem_mode", mem_mode, 1);
        @(negedge CLK);
        check("after rst still idle", in_ready, 0);
        in_valid = 1'b0;
        do_pass(table_v[0], 0, 1'b0, 1'b0, "post_rst");

        // Restart from DONE with all-0xFF.
        do_pass(table_v[2], 0, 1'b0, 1'b0, "restart");

        // start and in_valid together: byte 0x12 must not be taken.
        do_pass(table_v[1], 0, 1'b0, 1'b1, "vws");

        // Randomized passes against the reference model.
        for (int r = 0; r < 6; r++) begin
            vec8_t b;
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
            ref_pass(b, rv);
            do_pass(rv, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
